fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL provide parameter ADDR_W, default 14, instruction-SRAM word-address width.
REQ-003 SHALL provide parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 redirect_valid  input  1  branch/jump redirect from CPU.
REQ-007 redirect_pc  input  32  new fetch byte address.
REQ-008 im_req  output  1  instruction-SRAM read enable (drives CS).
REQ-009 im_addr  output  ADDR_W  SRAM word address = fpc[ADDR_W+1:2].
REQ-010 im_rdata  input  32  SRAM read data, valid the cycle after im_req.
REQ-011 out_valid  output  1  head entry available to decode.
REQ-012 out_instr  output  32  head instruction.
REQ-013 out_pc  output  32  byte PC of head instruction.
REQ-014 out_ready  input  1  decode accepts head.

Function
REQ-015 SHALL hold fetch PC fpc, FIFO of DEPTH {instr, pc} entries, count, one-deep in-flight tracker (valid bit + PC).
REQ-016 SHALL assert im_req in a cycle iff not rst, not redirect_valid, and count + inflight < DEPTH; the pop in the same cycle is not credited.
REQ-017 On each issued request: in-flight PC <= fpc, inflight <= 1, fpc <= fpc + 4 (mod 2^32 wrap).
REQ-018 Cycle after a request with no intervening redirect: SHALL push {im_rdata, in-flight PC} into FIFO; inflight cleared unless a new request issued.
REQ-019 out_valid SHALL equal (count != 0) AND NOT redirect_valid; out_instr/out_pc SHALL show head entry.
REQ-020 Pop SHALL occur iff out_valid && out_ready; simultaneous push and pop leaves count unchanged.
REQ-021 Credit rule SHALL guarantee no push when full; overflow is unreachable and SHALL be asserted against.
REQ-022 Sustained throughput SHALL be one instruction per cycle when out_ready is held high (DEPTH>=4).
REQ-023 Redirect cycle: FIFO emptied (count=0), pop ignored, response arriving that cycle dropped, in-flight killed, im_req=0, fpc <= {redirect_pc[31:2], 2'b00}.
REQ-024 Redirect latency: redirect at cycle N -> im_req with im_addr of redirect_pc at N+1 -> push at end of N+2 -> out_valid at N+3.
REQ-025 Back-to-back redirects: last one wins; each flushes.
REQ-026 redirect_pc[1:0] SHALL be ignored.
REQ-027 out_instr/out_pc SHALL be 0 when FIFO empty and never written since reset.

Reset
REQ-028 During rst: im_req=0, out_valid=0, count=0, inflight=0, fpc <= RESET_PC, FIFO storage cleared to 0.
REQ-029 rst has priority over redirect_valid and out_ready; a response arriving in a reset cycle SHALL be dropped.
REQ-030 First im_req SHALL assert in the first cycle rst is low, with im_addr = RESET_PC[ADDR_W+1:2].

Verification
REQ-031 Reset release, out_ready=1, SRAM returns word index as data: im_addr 0,1,2,... from cycle 1; out_valid from cycle 3; out_pc 0,4,8 with out_instr 0,1,2, one per cycle.
REQ-032 out_ready=0 for 10 cycles: exactly DEPTH=4 requests issued, count=4, im_req stays 0; out_ready=1 then drains pc 0,4,8,12 in order with no loss/duplication.
REQ-033 Redirect to 32'h0000_0103 while FIFO holds 3 entries and one in flight: next cycle im_addr=0x40, out_valid=0 until N+3, first out_pc=32'h100; stale data never emitted.
REQ-034 Redirect on cycles N and N+1 (0x200 then 0x300): only 0x300 stream emerges, first out_pc=0x300 at N+4.
REQ-035 fpc=32'hFFFF_FFFC fetch: next PC wraps to 0, out_pc sequence FFFF_FFFC, 0000_0000.
REQ-036 rst asserted mid-stream with FIFO full and out_ready=1: next cycle out_valid=0, count=0, no pop recorded; resumes at RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential SRAM reads under a credit limit
// and buffers {instr, pc} pairs in a small FIFO in front of decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [31:0]       im_rdata,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    input  logic              out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       fpc;
    logic              inflight;
    logic [31:0]       inflight_pc;

    logic [CNT_W-1:0]  credit_used;
    logic              push;
    logic              pop;

    // An outstanding read already owns a slot, so it is counted against the
    // FIFO space; a pop in this cycle is deliberately not credited.
    assign credit_used = count + CNT_W'(inflight);
    assign im_req      = !rst && !redirect_valid && (credit_used < CNT_W'(DEPTH));
    assign im_addr     = fpc[ADDR_W+1:2];

    assign push      = inflight && !rst && !redirect_valid;
    assign out_valid = !rst && !redirect_valid && (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_instr = mem[rd_ptr].instr;
    assign out_pc    = mem[rd_ptr].pc;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values of its neighbours regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            // NOTE: the storage itself is reset so an never-written head reads
            // as zero; this costs a reset on every bit of the array.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            fpc      <= redirect_pc & 32'hFFFF_FFFC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{instr: im_rdata, pc: inflight_pc};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (im_req) begin
                inflight_pc <= fpc;
                inflight    <= 1'b1;
                fpc         <= fpc + 32'd4;
            end else if (push) begin
                inflight <= 1'b0;
            end
        end
    end

    // The credit rule makes a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == CNT_W'(DEPTH)));
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// with a scoreboard fed by a stream-level model of the fetch sequence.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 14;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_rdata = '0;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic              out_ready = 1'b0;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stream_pc;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_pops = 0;
    int          n_req  = 0;

    // SRAM contents: each word holds its own word index.
    function automatic logic [31:0] sram_word(input logic [ADDR_W-1:0] a);
        return 32'(a);
    endfunction

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        logic [ADDR_W-1:0] w;
        w = pc[ADDR_W+1:2];
        return sram_word(w);
    endfunction

    always @(posedge clk) begin
        im_rdata <= im_req ? sram_word(im_addr) : (32'hBAD0_0000 | 32'($urandom_range(0, 255)));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The fetch stream after any restart is start, start+4, ... (32-bit wrap).
    task automatic refill();
        while (exp_q.size() < 32) begin
            exp_q.push_back('{pc: stream_pc, instr: instr_at(stream_pc)});
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        stream_pc = pc & 32'hFFFF_FFFC;
        refill();
    endtask

    // Monitor: compare every accepted head entry against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (out_valid === 1'b1 && out_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stream_pc", out_pc, e.pc);
            check("stream_instr", out_instr, e.instr);
            n_pops++;
            refill();
        end
    end

    // One cycle of stimulus; outputs settle by #1 for directed checks.
    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic ordy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = ordy;
        if (r) restart(RESET_PC);
        else if (rv) restart(rpc);
        #1;
        if (im_req) n_req++;
    endtask

    initial begin
        int snap;
        restart(RESET_PC);

        // Reset state and startup sequence at full throughput.
        repeat (3) cyc(1, 0, 0, 1);
        check("rst_im_req", 32'(im_req), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        cyc(0, 0, 0, 1);
        check("c1_im_req", 32'(im_req), 1);
        check("c1_im_addr", 32'(im_addr), 32'(RESET_PC[ADDR_W+1:2]));
        check("c1_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("c2_im_addr", 32'(im_addr), 1);
        check("c2_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("c3_out_valid", 32'(out_valid), 1);
        check("c3_out_pc", out_pc, 0);
        snap = n_pops;
        repeat (20) cyc(0, 0, 0, 1);
        check("throughput_pops", 32'(n_pops - snap), 20);

        // Stall: exactly DEPTH requests, then drain in order.
        repeat (2) cyc(1, 0, 0, 0);
        n_req = 0;
        repeat (10) cyc(0, 0, 0, 0);
        check("stall_req_count", 32'(n_req), DEPTH);
        check("stall_im_req", 32'(im_req), 0);
        check("stall_out_valid", 32'(out_valid), 1);
        snap = n_pops;
        repeat (10) cyc(0, 0, 0, 1);
        check("drain_pops", 32'(n_pops >= snap + DEPTH), 1);

        // Redirect with 3 buffered entries and one in flight.
        repeat (2) cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h0000_0103, 0);
        check("rd_n_im_req", 32'(im_req), 0);
        check("rd_n_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 0);
        check("rd_n1_im_req", 32'(im_req), 1);
        check("rd_n1_im_addr", 32'(im_addr), 32'h40);
        check("rd_n1_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 0);
        check("rd_n2_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("rd_n3_out_valid", 32'(out_valid), 1);
        check("rd_n3_out_pc", out_pc, 32'h100);
        repeat (8) cyc(0, 0, 0, 1);

        // Back-to-back redirects: the second one wins.
        cyc(0, 1, 32'h200, 1);
        cyc(0, 1, 32'h300, 1);
        check("b2b_n1_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("b2b_n2_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("b2b_n3_out_valid", 32'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("b2b_n4_out_valid", 32'(out_valid), 1);
        check("b2b_n4_out_pc", out_pc, 32'h300);
        repeat (6) cyc(0, 0, 0, 1);

        // Fetch PC wrap-around.
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        repeat (2) cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        check("wrap_pc1", out_pc, 32'h0);
        repeat (6) cyc(0, 0, 0, 1);

        // Reset mid-stream with a full FIFO and decode ready.
        repeat (8) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_im_req", 32'(im_req), 0);
        cyc(0, 0, 0, 1);
        check("post_rst_out_valid", 32'(out_valid), 0);
        check("post_rst_im_req", 32'(im_req), 1);
        check("post_rst_im_addr", 32'(im_addr), 32'(RESET_PC[ADDR_W+1:2]));
        repeat (6) cyc(0, 0, 0, 1);

        // Random traffic: redirects, back-pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic        r, rv, ordy;
            logic [31:0] rpc;
            r    = ($urandom_range(0, 299) == 0);
            rv   = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom());
            cyc(r, rv, rpc, ordy);
        end
        repeat (4) cyc(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
